// File: rtl/data_mem_responder.sv
// Single-port data memory responder with a programmable wait latency and a held response.
// Optional DMEM_RANGE_CHECK_EN flags and suppresses accesses at or above DEPTH.
module data_mem_responder #(
    parameter int ADDR        = 32,
    parameter int W_OPR       = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_v_i,
    output logic             req_stall_o,
    input  logic [ADDR-1:0]  req_addr_i,
    input  logic             req_write_i,
    input  logic [W_OPR-1:0] req_data_i,
    output logic             resp_v_o,
    input  logic             resp_stall_i,
    output logic [W_OPR-1:0] resp_data_o,
    output logic             err_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t             state_reg, state_next;
    logic [3:0]         cnt_reg, cnt_next;
    logic [IDX_W-1:0]   idx_reg;
    logic               write_reg;
    logic [W_OPR-1:0]   data_reg;
    logic               err_reg;

    logic               accept;
    logic               enter_resp;
    logic               req_oor;
    logic [IDX_W-1:0]   acc_idx;
    logic               acc_write;
    logic [W_OPR-1:0]   acc_data;
    logic               acc_err;
    logic               mem_we;

    logic [W_OPR-1:0]   mem [DEPTH];
    logic [W_OPR-1:0]   rd_data_reg;

`ifdef DMEM_RANGE_CHECK_EN
    assign req_oor = |req_addr_i[ADDR-1:IDX_W];
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr_i[ADDR-1:IDX_W];
    assign req_oor          = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        accept     = 1'b0;
        enter_resp = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_v_i) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES > 0) begin
                        state_next = WAIT;
                        cnt_next   = CNT_INIT;
                    end else begin
                        state_next = RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt_reg == 4'd0) begin
                    state_next = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            RESP: begin
                if (!resp_stall_i) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // With zero wait the access happens on the accept edge, so it must use the live request.
    assign acc_idx   = (state_reg == IDLE) ? req_addr_i[IDX_W-1:0] : idx_reg;
    assign acc_write = (state_reg == IDLE) ? req_write_i : write_reg;
    assign acc_data  = (state_reg == IDLE) ? req_data_i : data_reg;
    assign acc_err   = (state_reg == IDLE) ? req_oor : err_reg;

    // Gating with reset keeps a store from landing on an edge where reset is held low.
    assign mem_we = enter_resp && acc_write && !acc_err && reset;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            idx_reg   <= '0;
            write_reg <= 1'b0;
            data_reg  <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                idx_reg   <= req_addr_i[IDX_W-1:0];
                write_reg <= req_write_i;
                data_reg  <= req_data_i;
                err_reg   <= req_oor;
            end
        end
    end

    // Storage keeps its contents across reset, so it lives in a clock-only block.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[acc_idx] <= acc_data;
        end
        if (enter_resp) begin
            rd_data_reg <= mem[acc_idx];
        end
    end

    assign req_stall_o = (state_reg != IDLE);
    assign resp_v_o    = (state_reg == RESP);
    assign resp_data_o = (resp_v_o && !write_reg && !err_reg) ? rd_data_reg : '0;
    assign err_o       = resp_v_o && err_reg;

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter ADDR, 32, request address width in bits.
REQ-002 SHALL have parameter W_OPR, 32, data width in bits.
REQ-003 SHALL have parameter DEPTH, 256, number of storage words (power of two).
REQ-004 SHALL have parameter WAIT_CYCLES, 2, added access latency (0..15).
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port req_v_i  input  1  request valid from the execute stage.
REQ-008 SHALL have port req_stall_o  output  1  responder busy; a request is not accepted while high.
REQ-009 SHALL have port req_addr_i  input  ADDR  word address.
REQ-010 SHALL have port req_write_i  input  1  1 = store, 0 = load.
REQ-011 SHALL have port req_data_i  input  W_OPR  store data.
REQ-012 SHALL have port resp_v_o  output  1  response valid.
REQ-013 SHALL have port resp_stall_i  input  1  consumer stall; the response is held while high.
REQ-014 SHALL have port resp_data_o  output  W_OPR  load data; 0 for stores.
REQ-015 SHALL have port err_o  output  1  out-of-range flag, qualified by resp_v_o.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-017 SHALL drive req_stall_o = 1 in every state except IDLE.
REQ-018 SHALL accept a request on an edge in IDLE with req_v_i=1, capturing addr, write and data.
- Next state: WAIT if WAIT_CYCLES>0, else RESP.
REQ-019 SHALL load a down-counter with WAIT_CYCLES-1 on accept; in WAIT, decrement each cycle and go to RESP on the edge where the counter is 0.
REQ-020 SHALL perform the array access on the edge entering RESP.
- Store: writes the array.
- Load: registers array data into resp_data_o.
REQ-021 SHALL hold resp_v_o=1 exactly while in RESP, with resp_data_o and err_o stable.
REQ-022 SHALL leave RESP for IDLE on the edge where resp_stall_i=0; resp_stall_i=1 holds RESP indefinitely.
REQ-023 SHALL give latency from accept edge to first resp_v_o=1 cycle of WAIT_CYCLES+1 edges; minimum request spacing is WAIT_CYCLES+2 cycles.
REQ-024 SHALL index storage with req_addr_i[log2(DEPTH)-1:0].
REQ-025 SHALL, in a load immediately following a store to the same address, return the stored value.
REQ-026 SHALL ignore req_v_i, req_addr_i, req_write_i and req_data_i outside IDLE.

Reset
REQ-027 SHALL on reset=0 immediately force state IDLE, counter 0, resp_v_o=0, resp_data_o=0, err_o=0, req_stall_o=0.
REQ-028 SHALL, if reset is asserted while in WAIT, drop the pending request; a store from that request SHALL not be written.
REQ-029 SHALL NOT reset the storage array; contents survive reset.

Configuration
REQ-030 SHALL support macro DMEM_RANGE_CHECK_EN.
- Defined: any req_addr_i >= DEPTH sets err_o=1 in RESP, suppresses the store, and makes a load return 0.
- Undefined: addresses wrap modulo DEPTH and err_o is constant 0.

Verification
REQ-031 SHALL cover: WAIT_CYCLES=2, store addr 0x10 data 0xDEADBEEF, then load 0x10 -> each response 3 edges after accept; load data 0xDEADBEEF, err_o=0.
REQ-032 SHALL cover: resp_stall_i=1 for 5 cycles during a load response -> resp_v_o and data held for 6 cycles; req_stall_o=1 throughout; a new req_v_i is not accepted.
REQ-033 SHALL cover: WAIT_CYCLES=0, back-to-back req_v_i -> accepts every 2nd cycle; resp_v_o 1 edge after each accept.
REQ-034 SHALL cover: reset=0 asserted 1 cycle after accepting store 0x20 <- 0x12345678 -> outputs 0 immediately; a later load 0x20 returns the prior contents.
REQ-035 SHALL cover: with DMEM_RANGE_CHECK_EN, store to 0x100 (DEPTH=256) -> err_o=1 and addr 0x00 unchanged; without the macro -> err_o=0 and addr 0x00 overwritten.
